i2s_rx_array: RTL and testbench

Parametrised multi-line I2S master receiver for the beamformer front end. It generates the word-select (WS) from the system bit clock and deserialises NUM_LINES microphone data lines in parallel. It emits one packed word per channel slot, all lanes aligned and tagged left/right, to feed the per-channel delay buffers. It supersedes the single-line fixed-width receiver: width, slot length and lane count are parameters, and it adds an enable, a channel tag and an optional backpressure/overrun path.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_rx_lane.sv | 36 +++
 rtl/i2s_rx_array.sv | 125 ++++++++++++
 tb/tb_i2s_rx_array.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants for the multi-line I2S receiver: channel tags, default geometry
// and the slot-counter width helper.
package i2s_pkg;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  localparam int DEF_NUM_LINES   = 8;
  localparam int DEF_SAMPLE_BITS = 8;
  localparam int DEF_SLOT_BITS   = 32;

  function automatic int cnt_width(input int slot_bits);
    return (slot_bits > 2) ? $clog2(slot_bits) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_SLOT_BITS);

endpackage

// File: rtl/i2s_rx_lane.sv
// One I2S data lane: accumulates the leading SAMPLE_BITS-1 bits of a slot; the final
// bit is taken straight from the line so the full word is ready on the completion edge.
module i2s_rx_lane #(
  parameter int SAMPLE_BITS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   shift_i,
  input  logic                   sd_i,
  output logic [SAMPLE_BITS-1:0] word_o
);

  logic [SAMPLE_BITS-2:0] shift_q;
  logic [SAMPLE_BITS-2:0] shift_d;

  assign word_o = {shift_q, sd_i};

  always_comb begin
    shift_d = shift_q;
    if (clr_i) begin
      shift_d = '0;
    end else if (shift_i) begin
      shift_d = word_o[SAMPLE_BITS-2:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/i2s_rx_array.sv
// Multi-line I2S master receiver: generates WS, deserialises NUM_LINES lanes in lockstep
// and emits one packed, channel-tagged word set per slot. Optional macro I2S_RX_OVERRUN_EN
// turns the valid pulse into a valid/ready handshake with a sticky overrun flag.
module i2s_rx_array
  import i2s_pkg::*;
#(
  parameter int NUM_LINES   = DEF_NUM_LINES,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int SLOT_BITS   = DEF_SLOT_BITS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ena,
  input  logic [NUM_LINES-1:0]             sd_in,
  output logic                             ws_out,
  output logic [NUM_LINES*SAMPLE_BITS-1:0] sample_data,
  output logic                             sample_ch,
  output logic                             sample_valid,
  input  logic                             sample_ready,
  output logic                             overrun
);

  localparam int              CW       = cnt_width(SLOT_BITS);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0]   CNT_DONE = CW'(SAMPLE_BITS);

  logic [CW-1:0]                    cnt_q, cnt_d;
  logic                             ws_q, ws_d;
  logic [NUM_LINES*SAMPLE_BITS-1:0] data_q, data_d;
  logic [NUM_LINES*SAMPLE_BITS-1:0] word_all;
  logic                             ch_q, ch_d;
  logic                             valid_q, valid_d;
  logic                             ovr_q, ovr_d;
  logic                             capture;
  logic                             complete;

  // One-bit I2S delay: slot position 0 carries the previous word's LSB.
  assign capture  = ena && (cnt_q != '0) && (cnt_q <= CNT_DONE);
  assign complete = ena && (cnt_q == CNT_DONE);

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_lane
      i2s_rx_lane #(
        .SAMPLE_BITS(SAMPLE_BITS)
      ) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (!ena),
        .shift_i(capture),
        .sd_i   (sd_in[gi]),
        .word_o (word_all[gi*SAMPLE_BITS +: SAMPLE_BITS])
      );
    end
  endgenerate

`ifndef I2S_RX_OVERRUN_EN
  logic unused_ready;
  assign unused_ready = sample_ready;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    ws_d    = ws_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (!ena) begin
      cnt_d   = '0;
      ws_d    = CH_LEFT;
      ch_d    = CH_LEFT;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        ws_d  = ~ws_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`ifdef I2S_RX_OVERRUN_EN
      // A completion wins over an acceptance on the same edge.
      if (complete) begin
        if (valid_q && !sample_ready) begin
          ovr_d = 1'b1;
        end
        valid_d = 1'b1;
      end else if (valid_q && sample_ready) begin
        valid_d = 1'b0;
      end
`else
      valid_d = complete;
`endif
      if (complete) begin
        data_d = word_all;
        ch_d   = ws_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ws_q    <= CH_LEFT;
      data_q  <= '0;
      ch_q    <= CH_LEFT;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ws_q    <= ws_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ws_out       = ws_q;
  assign sample_data  = data_q;
  assign sample_ch    = ch_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_i2s_rx_array.sv
// Self-checking bench for i2s_rx_array: random microphone words per slot, checked edge by
// edge against a slot/position model; handshake tests run when I2S_RX_OVERRUN_EN is set.
module tb_i2s_rx_array;

  localparam int NL   = 8;
  localparam int SB   = 8;
  localparam int SLOT = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic [NL-1:0]    sd_in;
  logic             ws_out;
  logic [NL*SB-1:0] sample_data;
  logic             sample_ch;
  logic             sample_valid;
  logic             sample_ready;
  logic             overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i2s_rx_array #(
    .NUM_LINES  (NL),
    .SAMPLE_BITS(SB),
    .SLOT_BITS  (SLOT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .sd_in       (sd_in),
    .ws_out      (ws_out),
    .sample_data (sample_data),
    .sample_ch   (sample_ch),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun     (overrun)
  );

  // Reference model: k counts enabled edges since enable; mic_w holds each lane's
  // 32-bit microphone word for the current slot, sent MSB first from slot position 1.
  int               k;
  int               word_mode;
  logic [31:0]      mic_w [NL];
  logic             exp_valid, exp_ch, exp_ws, exp_ovr;
  logic [NL*SB-1:0] exp_data;
  logic [NL*SB+3:0] exp_vec;
  logic [NL*SB+3:0] obs;

  assign obs = {ws_out, sample_valid, sample_ch, overrun, sample_data};

  task automatic update_exp();
    exp_vec = {exp_ws, exp_valid, exp_ch, exp_ovr, exp_data};
  endtask

  task automatic model_reset();
    k         = 0;
    exp_valid = 1'b0;
    exp_ch    = 1'b0;
    exp_ws    = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  task automatic load_words(input int s);
    for (int i = 0; i < NL; i++) begin
      mic_w[i] = $urandom;
      case (word_mode)
        1: mic_w[i][31:24] = (i == 0) ? ((s % 2 == 0) ? 8'hA5 : 8'h3C)
                                      : ((s % 2 == 0) ? 8'h00 : 8'hFF);
        2: if (i == 0) mic_w[i][31:8] = 24'h123456;
        3: case (i)
             0: mic_w[i][31:24] = 8'h01;
             1: mic_w[i][31:24] = 8'h80;
             2: mic_w[i][31:24] = 8'h7F;
             3: mic_w[i][31:24] = 8'hFE;
             default: ;
           endcase
        default: ;
      endcase
    end
  endtask

  task automatic do_edge(input logic en, input logic rdy);
    int   p, s, idx;
    logic complete;
    p = k % SLOT;
    s = k / SLOT;
    if (en && p == 0) load_words(s);
    ena          = en;
    sample_ready = rdy;
    idx          = (p >= 1) ? (32 - p) : 0;
    for (int i = 0; i < NL; i++) begin
      sd_in[i] = (en && p >= 1) ? mic_w[i][idx] : 1'($urandom_range(1));
    end
    @(posedge clk);
    complete = en && (p == SB);
    if (!en) begin
      model_reset();
    end else begin
`ifdef I2S_RX_OVERRUN_EN
      if (complete) begin
        if (exp_valid && !rdy) exp_ovr = 1'b1;
        exp_valid = 1'b1;
      end else if (exp_valid && rdy) begin
        exp_valid = 1'b0;
      end
`else
      exp_valid = complete;
`endif
      if (complete) begin
        for (int i = 0; i < NL; i++) exp_data[i*SB +: SB] = mic_w[i][31 -: SB];
        exp_ch = (s % 2 == 1);
      end
      exp_ws = (((k + 1) / SLOT) % 2 == 1);
      k++;
    end
    update_exp();
    #1;
    if (complete) $display("txn edge=%0d ch=%0d data=%h ovr=%0d", k - 1, sample_ch, sample_data, overrun);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0; sample_ready = 1'b0; sd_in = '0;
    word_mode = 0;
    model_reset();
    exp_data = '0;
    update_exp();
    #3;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs, exp_vec);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    word_mode = 1;
    do_edge(1'b0, 1'b0);
    for (int n = 0; n < 2 * SLOT + 4; n++) begin
      do_edge(1'b1, 1'($urandom_range(1)));
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL fixed edge=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
      if (k - 1 == SB || k - 1 == SLOT + SB) begin
        checks++;
        if (sample_valid !== 1'b1 || sample_ch !== (k - 1 == SLOT + SB) ||
            sample_data[7:0] !== ((k - 1 == SB) ? 8'hA5 : 8'h3C)) begin
          errors++;
          $display("FAIL fixed_word edge=%0d got v=%b ch=%b lane0=%h", k - 1, sample_valid, sample_ch, sample_data[7:0]);
        end
      end
    end
  endtask

  task automatic test_truncation();
    word_mode = 2;
    do_edge(1'b0, 1'b0);
    for (int n = 0; n <= SB + 2; n++) begin
      do_edge(1'b1, 1'b1);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL trunc edge=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
      if (k - 1 == SB) begin
        checks++;
        if (sample_valid !== 1'b1 || sample_data[7:0] !== 8'h12) begin
          errors++;
          $display("FAIL trunc_word got v=%b lane0=%h exp v=1 lane0=12", sample_valid, sample_data[7:0]);
        end
      end
    end
  endtask

  task automatic test_lanes();
    word_mode = 3;
    do_edge(1'b0, 1'b0);
    for (int n = 0; n <= SB + 2; n++) begin
      do_edge(1'b1, 1'b1);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL lanes edge=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
      if (k - 1 == SB) begin
        checks++;
        if (sample_valid !== 1'b1 || sample_data[31:0] !== 32'hFE7F8001) begin
          errors++;
          $display("FAIL lanes_packed got v=%b data=%h exp v=1 data=fe7f8001", sample_valid, sample_data[31:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    word_mode = 0;
    do_edge(1'b0, 1'b0);
    for (int n = 0; n < 4 * SLOT; n++) begin
      do_edge(1'b1, 1'($urandom_range(1)));
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL random edge=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    word_mode = 0;
    do_edge(1'b0, 1'b0);
    for (int n = 0; n < SLOT + 5; n++) do_edge(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0", obs);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    exp_data = '0;
    update_exp();
    for (int n = 0; n <= SB + 1; n++) begin
      do_edge(1'b1, 1'b1);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL post_reset edge=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
    end
  endtask

  task automatic test_ena_low();
    word_mode = 0;
    do_edge(1'b0, 1'b0);
    for (int n = 0; n < SLOT + 12; n++) do_edge(1'b1, 1'b1);
    for (int n = 0; n < 3; n++) begin
      do_edge(1'b0, 1'b1);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL ena_low edge=%0d got=%h exp=%h", n, obs, exp_vec);
      end
    end
    for (int n = 0; n < SLOT + SB + 4; n++) begin
      do_edge(1'b1, 1'b1);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL ena_resume edge=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
    end
  endtask

`ifdef I2S_RX_OVERRUN_EN
  task automatic test_ready_on_completion();
    word_mode = 0;
    do_edge(1'b0, 1'b0);
    for (int n = 0; n <= SLOT + SB + 2; n++) begin
      do_edge(1'b1, (k % SLOT == SB) || (k > SLOT + SB));
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL ready_on_done edge=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
      if (k - 1 == SLOT + SB) begin
        checks++;
        if (sample_valid !== 1'b1 || overrun !== 1'b0 || sample_ch !== 1'b1) begin
          errors++;
          $display("FAIL ready_on_done_flags got v=%b ovr=%b ch=%b exp v=1 ovr=0 ch=1", sample_valid, overrun, sample_ch);
        end
      end
    end
  endtask

  task automatic test_overrun();
    word_mode = 0;
    do_edge(1'b0, 1'b0);
    for (int n = 0; n <= SLOT + SB; n++) begin
      do_edge(1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL overrun_hold edge=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
    end
    checks++;
    if (sample_valid !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got v=%b ovr=%b exp v=1 ovr=1", sample_valid, overrun);
    end
    for (int n = 0; n < 8; n++) begin
      do_edge(1'b1, 1'b1);
      checks++;
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL overrun_drain edge=%0d got=%h exp=%h", k - 1, obs, exp_vec);
      end
      if (n == 0) begin
        checks++;
        if (sample_valid !== 1'b0 || overrun !== 1'b1) begin
          errors++;
          $display("FAIL overrun_accept got v=%b ovr=%b exp v=0 ovr=1", sample_valid, overrun);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_truncation();
    test_lanes();
    test_random();
`ifdef I2S_RX_OVERRUN_EN
    test_ready_on_completion();
    test_overrun();
`endif
    test_async_reset();
    test_ena_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
